// File: rtl/scan_decoder_al.sv
// Registered active-low N-to-2^N decoder with enable.
// Direct mode decodes a loaded code; scan mode walks the low output on a prescaled step.
module scan_decoder_al #(
  parameter int unsigned N   = 2,
  parameter int unsigned DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      w,
  output logic [0:(2**N)-1] y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned NOUT = 2 ** N;
  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [N-1:0]  IDX_LAST = N'(NOUT - 1);

  logic [N-1:0]      r_idx;
  logic [PW-1:0]     r_pre;
  logic [0:NOUT-1]   r_y;
  logic              r_wrap;

  logic              w_step;
  logic [N-1:0]      w_idx_nx;
  logic [PW-1:0]     w_pre_nx;
  logic [0:NOUT-1]   w_y_nx;
  logic              w_wrap_nx;

  // Scan step is due when the prescaler completes its count; a load pre-empts it.
  always_comb begin
    w_step    = 1'b0;
    w_idx_nx  = r_idx;
    w_pre_nx  = r_pre;
    w_wrap_nx = 1'b0;

    if (mode && en && (r_pre == PRE_LAST) && !load) begin
      w_step = 1'b1;
    end

    if (load) begin
      w_idx_nx = w;
    end else if (w_step) begin
      w_idx_nx = r_idx + N'(1);
    end

    if (!mode || load) begin
      w_pre_nx = '0;
    end else if (en) begin
      w_pre_nx = (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
    end

    w_wrap_nx = w_step && (r_idx == IDX_LAST);
  end

  // Active-low one-hot of the next index; all lines inactive while disabled.
  always_comb begin
    w_y_nx = '1;
    for (int unsigned i = 0; i < NOUT; i++) begin
      if (en && (w_idx_nx == N'(i))) begin
        w_y_nx[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_pre  <= '0;
      r_y    <= '1;
      r_wrap <= 1'b0;
    end else begin
      r_idx  <= w_idx_nx;
      r_pre  <= w_pre_nx;
      r_y    <= w_y_nx;
      r_wrap <= w_wrap_nx;
    end
  end

  assign y    = r_y;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_scan_decoder_al.sv
// Self-checking bench for scan_decoder_al: N=2/DIV=4 and N=3/DIV=1 instances
// compared each cycle against a counting reference model.
module tb_scan_decoder_al;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_en, a_mode, a_load;
  logic [1:0] a_w, a_idx;
  logic [0:3] a_y;
  logic       a_wrap;

  logic       b_en, b_mode, b_load;
  logic [2:0] b_w, b_idx;
  logic [0:7] b_y;
  logic       b_wrap;

  scan_decoder_al #(.N(2), .DIV(4)) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode), .load(a_load),
    .w(a_w), .y(a_y), .idx(a_idx), .wrap(a_wrap)
  );

  scan_decoder_al #(.N(3), .DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .load(b_load),
    .w(b_w), .y(b_y), .idx(b_idx), .wrap(b_wrap)
  );

  int checks = 0;
  int errors = 0;

  int nn[2] = '{2, 3};
  int dv[2] = '{4, 1};
  int m_idx[2], m_cnt[2], m_wrap[2], m_y[2];
  int a_wraps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset(input int k);
    m_idx[k]  = 0;
    m_cnt[k]  = 0;
    m_wrap[k] = 0;
    m_y[k]    = (1 << (1 << nn[k])) - 1;
  endtask

  // m_cnt counts enabled scan cycles since the last step; a step fires on the DIV-th.
  task automatic mstep(input int k, input bit en, input bit mode, input bit load, input int w);
    int nout;
    nout = 1 << nn[k];
    m_wrap[k] = 0;
    if (load) begin
      m_idx[k] = w;
      m_cnt[k] = 0;
    end else if (!mode) begin
      m_cnt[k] = 0;
    end else if (en) begin
      m_cnt[k]++;
      if (m_cnt[k] == dv[k]) begin
        m_cnt[k] = 0;
        if (m_idx[k] == nout - 1) m_wrap[k] = 1;
        m_idx[k] = (m_idx[k] + 1) % nout;
      end
    end
    m_y[k] = (1 << nout) - 1;
    if (en) m_y[k] = m_y[k] & ~(1 << (nout - 1 - m_idx[k]));
  endtask

  task automatic check_all();
    check("a_y",    32'(a_y),    32'(m_y[0]));
    check("a_idx",  32'(a_idx),  32'(m_idx[0]));
    check("a_wrap", 32'(a_wrap), 32'(m_wrap[0]));
    check("b_y",    32'(b_y),    32'(m_y[1]));
    check("b_idx",  32'(b_idx),  32'(m_idx[1]));
    check("b_wrap", 32'(b_wrap), 32'(m_wrap[1]));
    check("a_onehot", 32'($countones(~a_y) <= 1), 32'(1));
    check("b_onehot", 32'($countones(~b_y) <= 1), 32'(1));
  endtask

  // One clock: advance the model with the inputs sampled at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      mstep(0, a_en, a_mode, a_load, int'(a_w));
      mstep(1, b_en, b_mode, b_load, int'(b_w));
    end else begin
      mreset(0);
      mreset(1);
    end
    #1;
    a_wraps += int'(a_wrap);
    check_all();
  endtask

  initial begin
    int dexp[4] = '{7, 11, 13, 14};
    a_en = 0; a_mode = 0; a_load = 0; a_w = 0;
    b_en = 0; b_mode = 0; b_load = 0; b_w = 0;
    a_wraps = 0;
    mreset(0); mreset(1);

    // Reset state
    tick(); tick();
    rst_n = 1'b1;

    // Direct decode
    a_en = 1; a_mode = 0;
    for (int i = 0; i < 4; i++) begin
      a_load = 1; a_w = 2'(i);
      tick();
      check("dir_y", 32'(a_y), 32'(dexp[i]));
      check("dir_idx", 32'(a_idx), 32'(i));
    end
    a_load = 0;

    // Enable gating
    a_load = 1; a_w = 2; tick(); a_load = 0;
    a_en = 0; tick();
    check("gate_off_y", 32'(a_y), 32'(15));
    a_load = 1; a_w = 3; tick(); a_load = 0;
    check("gate_load_idx", 32'(a_idx), 32'(3));
    check("gate_load_y", 32'(a_y), 32'(15));
    a_en = 1; tick();
    check("gate_on_y", 32'(a_y), 32'(14));

    // Asynchronous reset mid-run with y=1101
    a_load = 1; a_w = 2; tick(); a_load = 0;
    check("pre_rst_y", 32'(a_y), 32'(13));
    #2 rst_n = 1'b0;
    #1;
    mreset(0); mreset(1);
    check("rst_y", 32'(a_y), 32'(15));
    check("rst_idx", 32'(a_idx), 32'(0));
    check("rst_wrap", 32'(a_wrap), 32'(0));
    tick(); tick();
    rst_n = 1'b1;

    // Scan DIV=4 from idx 0: each value held 4 cycles, one wrap per 16
    a_en = 1; a_mode = 1; a_load = 1; a_w = 0;
    tick();
    a_load = 0;
    a_wraps = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("scan_idx", 32'(a_idx), 32'((i / 4) % 4));
      check("scan_wrap", 32'(a_wrap), 32'(i == 16));
    end
    check("scan_wrapcnt", 32'(a_wraps), 32'(1));

    // en gap of 5 cycles mid-step delays the step by 5
    tick(); tick();
    a_en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gap_y", 32'(a_y), 32'(15));
      check("gap_idx", 32'(a_idx), 32'(0));
    end
    a_en = 1;
    tick();
    check("gap_hold_idx", 32'(a_idx), 32'(0));
    tick();
    check("gap_step_idx", 32'(a_idx), 32'(1));

    // Load on the edge a 3->0 step is due
    repeat (8) tick();
    check("due_pre_idx", 32'(a_idx), 32'(3));
    repeat (3) tick();
    a_load = 1; a_w = 1;
    tick();
    a_load = 0;
    check("due_load_idx", 32'(a_idx), 32'(1));
    check("due_load_wrap", 32'(a_wrap), 32'(0));
    repeat (3) tick();
    check("due_hold_idx", 32'(a_idx), 32'(1));
    tick();
    check("due_step_idx", 32'(a_idx), 32'(2));

    // N=3, DIV=1 sweep
    b_en = 1; b_mode = 1; b_load = 1; b_w = 0;
    tick();
    b_load = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("sw_idx", 32'(b_idx), 32'(i % 8));
      check("sw_wrap", 32'(b_wrap), 32'((i % 8) == 0));
      check("sw_y", 32'(b_y), 32'(~(8'h80 >> (i % 8)) & 8'hFF));
    end

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      a_en   = ($urandom_range(0, 9) != 0);
      b_en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 15) == 0) b_mode = ~b_mode;
      a_load = ($urandom_range(0, 11) == 0);
      b_load = ($urandom_range(0, 11) == 0);
      a_w    = 2'($urandom);
      b_w    = 3'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_decoder_al.md
Name: scan_decoder_al

Overview:
- Parametrised, registered, active-low N-to-2^N decoder with enable. Successor to the combinational 2-to-4 active-low decoder.
- Two modes:
  - direct: a loaded select code drives one output low.
  - scan: an internal prescaled counter walks the single low output across all 2^N lines, for multiplexed display digit/row strobes.
- Sits between control logic and display/row drivers.

Parameters:
- N, 2, select width; output count is 2**N (derived, not overridable).
- DIV, 4, clock cycles per scan step in scan mode; legal range DIV >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  output enable; 0 forces all outputs inactive (high)
- mode  input  1  0 = direct, 1 = scan
- load  input  1  capture w into the index register
- w  input  N  select code
- y  output  [0:2**N-1]  active-low decoded outputs; y[i] low iff index == i and enabled
- idx  output  N  current index register
- wrap  output  1  one-cycle pulse when scan index wraps from 2**N-1 to 0

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - y = all ones; idx = 0; wrap = 0; prescaler = 0.
  - Holds while rst_n is low. First active edge after release behaves as normal operation.
- All outputs are registered; no combinational path from inputs to y, idx or wrap.
- Next index (idx_nx), by priority:
  1. load=1 -> idx_nx = w, in either mode.
  2. mode=1, en=1, prescaler == DIV-1 -> idx_nx = idx+1 modulo 2**N.
  3. Otherwise idx_nx = idx.
- y update: each edge, y <= en ? ~(one-hot of idx_nx) : all ones.
  - Latency is one edge: values sampled at edge k appear on y after edge k.
- Prescaler:
  - Width is ceil(log2(DIV)), minimum 1 bit.
  - Cleared when mode=0, when load=1, or when it reaches DIV-1 with en=1 and mode=1.
  - Otherwise increments when mode=1 and en=1; holds when en=0.
  - DIV=1: index steps on every enabled scan cycle.
- wrap: 1 for exactly one cycle, on the edge where a scan step takes idx from 2**N-1 to 0.
  - A load to 0 does not assert wrap.
  - wrap is always 0 when en=0 or mode=0.
- en=0:
  - y = all ones after the next edge; idx and prescaler hold.
  - load still updates idx, so the code is visible once en returns.
  - Re-enabling resumes the scan from the held prescaler count.
- Mode switch:
  - 1->0: idx holds (unless loaded); prescaler clears.
  - 0->1: scanning starts from the current idx; the first step occurs DIV enabled cycles later.
- Simultaneous events:
  - load together with a due scan step: load wins, no wrap, prescaler cleared.
  - load with en=0: idx updates, y stays all ones.
- At most one bit of y is ever 0 (one-hot-low invariant). No X on outputs after reset.

Test Plan:
- Reset, then hold it: rst_n=0 mid-run with y=1101 -> y=1111, idx=0, wrap=0 immediately, without waiting for a clock edge; they hold while low.
- Direct decode, N=2, en=1, mode=0: load w=0,1,2,3 on successive edges -> y = 0111, 1011, 1101, 1110 one edge after each load; idx matches w.
- Enable gating: idx=2, en=0 -> y=1111 after next edge; load w=3 while en=0 -> idx=3, y=1111; en=1 -> y=1110 after next edge.
- Scan with DIV=4, from idx=0:
  - idx advances 0->1->2->3->0, each value held 4 cycles.
  - y walks 0111, 1011, 1101, 1110.
  - wrap high for exactly 1 cycle at the 3->0 step; 16-cycle period.
- Scan corner cases:
  - en deasserted mid-step for 5 cycles: step is delayed by exactly 5 cycles; y=1111 during the gap.
  - load w=1 on the same edge a 3->0 step is due: idx=1, no wrap, next step after 4 cycles.
- Parameter sweep N=3, DIV=1: scan gives idx 0..7 on consecutive cycles, one low bit per cycle in y[0:7], wrap every 8 cycles.
